// File: rtl/quick_spi_slave.sv
// SPI responder (slave) oversampling sclk/ss_n/mosi in the clk domain; words of 1..64 bits, any CPOL/CPHA, either bit order.
// Latency: rx_valid rises SYNC_STAGES+1 clk after the final sampling sclk edge at the pin.
// Backpressure: none toward the master; a one-word tx buffer (tx_ready/tx_load) feeds the next outgoing word, idle fill if empty.
module quick_spi_slave #(
    parameter int   DATA_WIDTH      = 16,
    parameter bit   CPOL            = 1'b0,
    parameter bit   CPHA            = 1'b0,
    parameter bit   BITS_ORDER      = 1'b1,
    parameter logic MISO_IDLE_VALUE = 1'b0,
    parameter int   SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error,
    output logic                  busy,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe
);

    localparam logic [6:0]            WORD_LEN  = 7'(DATA_WIDTH);
    localparam logic [6:0]            LAST_BIT  = WORD_LEN - 7'd1;
    localparam logic [DATA_WIDTH-1:0] IDLE_FILL = {DATA_WIDTH{MISO_IDLE_VALUE}};

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_SELECTED = 1'b1
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sclk_prev;
    logic                   ss_prev;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchroniser chains. The ss_n chain and its history reset to "low" so a
    // select that is still asserted when reset releases is never mistaken for a
    // new falling edge; the master must raise ss_n and drop it again.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= CPOL;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    // ------------------------------------------------------------------
    // Edge classification on the synchronised sclk
    // ------------------------------------------------------------------
    logic leading_edge;
    logic trailing_edge;
    logic sample_edge;
    logic shift_edge;
    logic ss_fall;

    assign leading_edge  = (sclk_prev == CPOL) && (sclk_s != CPOL);
    assign trailing_edge = (sclk_prev != CPOL) && (sclk_s == CPOL);
    assign sample_edge   = CPHA ? trailing_edge : leading_edge;
    assign shift_edge    = CPHA ? leading_edge  : trailing_edge;
    assign ss_fall       = ss_prev && !ss_s;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [6:0] bit_cnt;
    logic       start_xfer;
    logic       end_xfer;
    logic       do_sample;
    logic       do_shift;
    logic       word_done;
    logic       frame_err_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes. A shift edge only advances the
    // tx word once at least one bit of the current word has been sampled, so
    // the freshly loaded bit 0 survives the first shift edge after select
    // (CPHA=1) and after a word boundary (CPHA=0).
    always_comb begin
        state_nxt     = state;
        start_xfer    = 1'b0;
        end_xfer      = 1'b0;
        do_sample     = 1'b0;
        do_shift      = 1'b0;
        word_done     = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall && enable) begin
                    state_nxt  = ST_SELECTED;
                    start_xfer = 1'b1;
                end
            end
            ST_SELECTED: begin
                if (ss_s || !enable) begin
                    state_nxt     = ST_IDLE;
                    end_xfer      = 1'b1;
                    frame_err_nxt = (bit_cnt != 7'd0);
                end else begin
                    if (sample_edge) begin
                        do_sample = 1'b1;
                        word_done = (bit_cnt == LAST_BIT);
                    end
                    if (shift_edge && (bit_cnt != 7'd0)) begin
                        do_shift = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bit counter: counts sampled bits of the word in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt <= 7'd0;
        end else if (start_xfer || end_xfer || word_done) begin
            bit_cnt <= 7'd0;
        end else if (do_sample) begin
            bit_cnt <= bit_cnt + 7'd1;
        end
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_shift_nxt;

    // Next receive word: MSB-first enters at bit 0 and moves up; LSB-first
    // enters at the top and moves down, so both end right-aligned.
    always_comb begin
        rx_shift_nxt = rx_shift;
        if (BITS_ORDER) begin
            rx_shift_nxt    = rx_shift << 1;
            rx_shift_nxt[0] = mosi_s;
        end else begin
            rx_shift_nxt               = rx_shift >> 1;
            rx_shift_nxt[DATA_WIDTH-1] = mosi_s;
        end
    end

    // Receive shift register and output word with its strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= word_done;
            frame_error <= frame_err_nxt;
            if (start_xfer) begin
                rx_shift <= '0;
            end else if (do_sample) begin
                rx_shift <= rx_shift_nxt;
            end
            if (word_done) begin
                rx_data <= rx_shift_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit buffer and shift register
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] tx_buf;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_shift_adv;
    logic                  take_buf;
    logic                  tx_accept;

    // The buffer is emptied into the shift register at select and at each
    // word boundary. A load landing on that same cycle is accepted even if the
    // buffer was full: the old word moves out and the new one takes its place.
    assign take_buf  = start_xfer || word_done;
    assign tx_accept = tx_load && (tx_ready || take_buf);

    // Advance direction follows the bit order; vacated bits are never presented.
    always_comb begin
        tx_shift_adv = tx_shift;
        if (BITS_ORDER) begin
            tx_shift_adv = tx_shift << 1;
        end else begin
            tx_shift_adv = tx_shift >> 1;
        end
    end

    // One-word tx buffer with its empty flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_buf   <= '0;
            tx_ready <= 1'b1;
        end else begin
            if (tx_accept) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (take_buf) begin
                tx_ready <= 1'b1;
            end
        end
    end

    // Outgoing shift register: reload at word start, advance on shift edges
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_shift <= IDLE_FILL;
        end else if (take_buf) begin
            tx_shift <= tx_ready ? IDLE_FILL : tx_buf;
        end else if (do_shift) begin
            tx_shift <= tx_shift_adv;
        end
    end

    // ------------------------------------------------------------------
    // Pin-facing outputs
    // ------------------------------------------------------------------
    assign busy    = (state == ST_SELECTED);
    assign miso_oe = (state == ST_SELECTED);
    assign miso    = (state == ST_SELECTED)
                   ? (BITS_ORDER ? tx_shift[DATA_WIDTH-1] : tx_shift[0])
                   : MISO_IDLE_VALUE;

endmodule
